uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter.sv | 126 ++++++++++++
 tb/tb_uart_transmitter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
// UART transmitter: 8N1 frames at Clk_per_bit Master_Clk cycles per bit, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and stop.
module uart_transmitter #(
  parameter int unsigned Clk_per_bit = 32
) (
  input  logic       Master_Clk,
  input  logic       Master_Rst_n,
  input  logic       Tx_DataValid,
  input  logic [7:0] Tx_Byte,
  output logic       Serial_Out,
  output logic       Tx_Active,
  output logic       Tx_Done
);

  localparam logic [7:0] CNT_LAST = 8'(Clk_per_bit - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY  = 3'd3,
`endif
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] byte_q, byte_d;
  logic       serial_d, active_d, done_d;
  logic       bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // Outputs are registered from the current state, so the line follows the
  // state register by one edge: acceptance at edge N shows the start bit at N+1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    serial_d = 1'b1;
    active_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (Tx_DataValid) begin
          byte_d  = Tx_Byte;
          state_d = START;
        end
      end
      START: begin
        serial_d = 1'b0;
        active_d = 1'b1;
        cnt_d    = bit_end ? '0 : 8'(cnt_q + 8'd1);
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        serial_d = byte_q[idx_q];
        active_d = 1'b1;
        cnt_d    = bit_end ? '0 : 8'(cnt_q + 8'd1);
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = 3'(idx_q + 3'd1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        serial_d = ^byte_q;
        active_d = 1'b1;
        cnt_d    = bit_end ? '0 : 8'(cnt_q + 8'd1);
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        active_d = 1'b1;
        cnt_d    = bit_end ? '0 : 8'(cnt_q + 8'd1);
        if (bit_end) state_d = CLEANUP;
      end
      CLEANUP: begin
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Master_Clk or negedge Master_Rst_n) begin
    if (!Master_Rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      byte_q     <= '0;
      Serial_Out <= 1'b1;
      Tx_Active  <= 1'b0;
      Tx_Done    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      Serial_Out <= serial_d;
      Tx_Active  <= active_d;
      Tx_Done    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
// Self-checking bench for uart_transmitter: table-driven frames decoded by a
// line monitor against a scoreboard queue, plus hand-written corner sequences.
module tb_uart_transmitter;

  localparam int unsigned CPB = 32;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FB       = 11;
  localparam int unsigned DONE_LAT = 353;
`else
  localparam int unsigned FB       = 10;
  localparam int unsigned DONE_LAT = 321;
`endif

  logic       Master_Clk   = 1'b0;
  logic       Master_Rst_n = 1'b0;
  logic       Tx_DataValid = 1'b0;
  logic [7:0] Tx_Byte      = 8'h00;
  logic       Serial_Out;
  logic       Tx_Active;
  logic       Tx_Done;

  uart_transmitter #(.Clk_per_bit(CPB)) dut (
    .Master_Clk   (Master_Clk),
    .Master_Rst_n (Master_Rst_n),
    .Tx_DataValid (Tx_DataValid),
    .Tx_Byte      (Tx_Byte),
    .Serial_Out   (Serial_Out),
    .Tx_Active    (Tx_Active),
    .Tx_Done      (Tx_Done)
  );

  always #5 Master_Clk = ~Master_Clk;

  typedef struct {
    logic [7:0] din;
    logic [9:0] frame8n1;  // line bits in time order from bit 0: start, d0..d7, stop
  } vec_t;

  vec_t        vecs[8];
  logic [10:0] exp_q[$];
  int          checks     = 0;
  int          errors     = 0;
  int          done_count = 0;
  int          frames_rx  = 0;
  int          frames_exp = 0;
  int unsigned cycle      = 0;

  always @(posedge Master_Clk) cycle <= cycle + 1;
  always @(negedge Master_Clk) if (Tx_Done === 1'b1) done_count <= done_count + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [10:0] to_exp(input logic [7:0] d, input logic [9:0] f);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, f[8:0]};
`else
    return {1'b0, f};
`endif
  endfunction

  function automatic logic [10:0] model_frame(input logic [7:0] d);
    return to_exp(d, {1'b1, d, 1'b0});
  endfunction

  // Line receiver: samples each bit near its centre; a reset inside a frame drops it.
  initial begin : monitor
    logic [10:0] cap;
    logic [10:0] e;
    logic        aborted;
    forever begin
      @(negedge Serial_Out);
      cap     = '0;
      aborted = 1'b0;
      for (int b = 0; b < int'(FB) && !aborted; b++) begin
        for (int c = 0; c < int'(CPB) && !aborted; c++) begin
          @(negedge Master_Clk);
          if (!Master_Rst_n) aborted = 1'b1;
          else if (c == int'(CPB / 2)) cap[b] = Serial_Out;
        end
      end
      if (!aborted) begin
        frames_rx++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected actual=%0h required=none", cap);
        end else begin
          e = exp_q.pop_front();
          check("frame", {21'd0, cap}, {21'd0, e});
        end
      end
    end
  end

  task automatic wait_done(input string name, input int unsigned acc);
    while (Tx_Done !== 1'b1 && (cycle - acc) < DONE_LAT + 50) begin
      @(posedge Master_Clk); #1;
    end
    check({name, "_done_lat"}, cycle - acc, DONE_LAT);
  endtask

  task automatic send_and_time(input logic [7:0] d, input logic [10:0] e, input string name);
    int unsigned acc;
    int          base;
    @(negedge Master_Clk);
    Tx_Byte      = d;
    Tx_DataValid = 1'b1;
    exp_q.push_back(e);
    frames_exp++;
    @(posedge Master_Clk); #1;
    Tx_DataValid = 1'b0;
    acc  = cycle;
    base = done_count;
    @(posedge Master_Clk); #1;
    check({name, "_start_low"}, {31'd0, Serial_Out}, 32'd0);
    check({name, "_active"}, {31'd0, Tx_Active}, 32'd1);
    wait_done(name, acc);
    check({name, "_cleanup_active"}, {31'd0, Tx_Active}, 32'd0);
    @(posedge Master_Clk); #1;
    check({name, "_done_pulse"}, {31'd0, Tx_Done}, 32'd0);
    check({name, "_done_count"}, done_count - base, 1);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned acc;
    int unsigned first_start;
    int unsigned second_start;
    int          base;
    logic        seen_done;

    vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
    vecs[1] = '{8'h00, 10'b1_0000_0000_0};
    vecs[2] = '{8'hFF, 10'b1_1111_1111_0};
    vecs[3] = '{8'h01, 10'b1_0000_0001_0};
    vecs[4] = '{8'h80, 10'b1_1000_0000_0};
    vecs[5] = '{8'h07, 10'b1_0000_0111_0};
    vecs[6] = '{8'h03, 10'b1_0000_0011_0};
    vecs[7] = '{8'h3C, 10'b1_0011_1100_0};

    repeat (3) @(posedge Master_Clk);
    #1;
    check("rst_serial", {31'd0, Serial_Out}, 32'd1);
    check("rst_active", {31'd0, Tx_Active}, 32'd0);
    check("rst_done", {31'd0, Tx_Done}, 32'd0);
    @(negedge Master_Clk);
    Master_Rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      send_and_time(vecs[i].din, to_exp(vecs[i].din, vecs[i].frame8n1), "vec");
    for (int v = 0; v < 256; v += 17)
      send_and_time(8'(v), model_frame(8'(v)), "sweep");
    for (int i = 0; i < 4; i++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      send_and_time(r, model_frame(r), "rand");
    end

    // A second request mid-frame must be ignored, and Tx_Byte changes must not leak in.
    @(negedge Master_Clk);
    Tx_Byte      = 8'h3C;
    Tx_DataValid = 1'b1;
    exp_q.push_back(to_exp(8'h3C, vecs[7].frame8n1));
    frames_exp++;
    @(posedge Master_Clk); #1;
    Tx_DataValid = 1'b0;
    acc  = cycle;
    base = done_count;
    repeat (98) @(posedge Master_Clk);
    @(negedge Master_Clk);
    Tx_Byte      = 8'hFF;
    Tx_DataValid = 1'b1;
    @(posedge Master_Clk); #1;
    Tx_DataValid = 1'b0;
    wait_done("ignore", acc);
    repeat (DONE_LAT + 20) @(posedge Master_Clk);
    #1;
    check("ignore_done_count", done_count - base, 1);
    check("ignore_queue", exp_q.size(), 0);

    // Held request: back-to-back frames, start edges one frame plus two cycles apart.
    @(negedge Master_Clk);
    Tx_Byte      = 8'h55;
    Tx_DataValid = 1'b1;
    exp_q.push_back(model_frame(8'h55));
    exp_q.push_back(model_frame(8'hAA));
    frames_exp += 2;
    @(posedge Master_Clk); #1;
    Tx_Byte      = 8'hAA;
    acc          = cycle;
    first_start  = 0;
    second_start = 0;
    seen_done    = 1'b0;
    while (second_start == 0 && (cycle - acc) < 2 * DONE_LAT + 20) begin
      @(posedge Master_Clk); #1;
      if (first_start == 0 && Serial_Out == 1'b0) first_start = cycle - acc;
      if (Tx_Done === 1'b1) seen_done = 1'b1;
      if (seen_done && Serial_Out == 1'b0) second_start = cycle - acc;
    end
    Tx_DataValid = 1'b0;
    check("b2b_first_start", first_start, 1);
    check("b2b_spacing", second_start - first_start, DONE_LAT + 1);
    wait_done("b2b_second", acc + DONE_LAT + 1);
    repeat (2) @(posedge Master_Clk);
    #1;

    // Reset mid-frame aborts without Tx_Done; the next byte goes out intact.
    @(negedge Master_Clk);
    Tx_Byte      = 8'h00;
    Tx_DataValid = 1'b1;
    @(posedge Master_Clk); #1;
    Tx_DataValid = 1'b0;
    base = done_count;
    repeat (150) @(posedge Master_Clk);
    #1;
    check("abort_line_low", {31'd0, Serial_Out}, 32'd0);
    Master_Rst_n = 1'b0;
    #1;
    check("abort_serial", {31'd0, Serial_Out}, 32'd1);
    check("abort_active", {31'd0, Tx_Active}, 32'd0);
    check("abort_done", {31'd0, Tx_Done}, 32'd0);
    repeat (2) @(posedge Master_Clk);
    #1;
    Master_Rst_n = 1'b1;
    send_and_time(8'h81, model_frame(8'h81), "after_rst");
    repeat (DONE_LAT) @(posedge Master_Clk);
    #1;
    check("abort_no_done", done_count - base, 1);

    repeat (5) @(posedge Master_Clk);
    #1;
    check("final_queue", exp_q.size(), 0);
    check("final_frames", frames_rx, frames_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
